// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file writeback port arbiter.
// Holds the zero-register constant, the mux select encodings for the two
// writeback sources and the arbiter FSM state encoding.
package wb_port_arbiter_pkg;

  // Architectural zero register: writes to it are accepted but discarded.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Select encodings for the downstream 5-bit write-address 2:1 mux.
  localparam logic WB_SRC_A = 1'b0;  // in-order pipeline writeback
  localparam logic WB_SRC_B = 1'b1;  // long-latency unit return

  // Stall counter is 4 bits wide and saturates here.
  localparam logic [3:0] STARVE_SAT = 4'hF;

  typedef enum logic {
    NORMAL  = 1'b0,
    FORCE_B = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_grant_logic.sv
// Combinational grant for the writeback port: picks A or B each cycle.
// Latency: zero (pure combinational); grants depend only on valids, addrs,
// force_b and en, never on the other grant.
// Ports: en (low forces no grant), a_valid/a_addr, b_valid/b_addr,
//        force_b (starvation override), grant_a/grant_b (at most one high).
module wb_grant_logic
  import wb_port_arbiter_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          en,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic          force_b,
  output logic          grant_a,
  output logic          grant_b
);

  logic waw_hit;

  // Same non-zero destination: B is the older result, so it must land first
  // and let A's younger value overwrite it on a later cycle.
  assign waw_hit = (a_addr == b_addr) && (a_addr != AW'(REG_ZERO));

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (en) begin
      if (a_valid && b_valid) begin
        if (force_b || waw_hit) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b1;
        end
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback
// (A) and long-latency returns (B). Latency: grant is same-cycle, write port
// outputs are registered one cycle after the handshake. Backpressure: the
// losing source sees ready low and simply retries; B is forced through after
// STARVE_LIMIT consecutive stalled cycles, and only for one transfer.
// Ports: clk, rst_n (sync, active-low); a_valid/a_addr/a_data/a_ready;
//        b_valid/b_addr/b_data/b_ready; wb_sel/wb_addr/wb_data/wb_we
//        (registered write port); starve_cnt (current B stall count).
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DW           = 32,
  parameter int AW           = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          wb_sel,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          wb_we,
  output logic [3:0]    starve_cnt
);

  // Count value at which one more stalled cycle hands B the override.
  localparam logic [3:0] STARVE_TRIG = 4'(STARVE_LIMIT - 1);

  arb_state_t    state_q;
  arb_state_t    state_d;
  logic [3:0]    starve_d;
  logic          grant_a;
  logic          grant_b;
  logic          a_fire;
  logic          b_fire;
  logic          b_stall;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // Reset gates the grants so a handshake in flight at reset is dropped.
  wb_grant_logic #(
    .AW(AW)
  ) u_grant (
    .en      (rst_n),
    .a_valid (a_valid),
    .a_addr  (a_addr),
    .b_valid (b_valid),
    .b_addr  (b_addr),
    .force_b (state_q == FORCE_B),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign a_fire   = a_valid && grant_a;
  assign b_fire   = b_valid && grant_b;
  assign b_stall  = b_valid && !grant_b;
  assign sel_addr = b_fire ? b_addr : a_addr;
  assign sel_data = b_fire ? b_data : a_data;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_cnt;

    if (!b_valid || b_fire) begin
      starve_d = 4'd0;
    end else if (starve_cnt != STARVE_SAT) begin
      starve_d = starve_cnt + 4'd1;
    end

    case (state_q)
      NORMAL: begin
        if (b_stall && (starve_cnt == STARVE_TRIG)) begin
          state_d = FORCE_B;
        end
      end
      FORCE_B: begin
        // Leaves after exactly one B transfer, so A cannot be starved.
        if (b_fire || !b_valid) begin
          state_d = NORMAL;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= NORMAL;
      starve_cnt <= 4'd0;
    end else begin
      state_q    <= state_d;
      starve_cnt <= starve_d;
    end
  end

  // Write port stage: select/addr/data hold when idle, only the enable drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_we   <= 1'b0;
      wb_sel  <= WB_SRC_A;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (a_fire || b_fire) begin
      wb_sel  <= b_fire ? WB_SRC_B : WB_SRC_A;
      wb_addr <= sel_addr;
      wb_data <= sel_data;
      wb_we   <= (sel_addr != AW'(REG_ZERO));
    end else begin
      wb_we   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          wb_sel, wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [3:0]    starve_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: how many cycles in a row B has waited, and what the
  // write port must show after the most recent edge.
  int            m_wait = 0;
  logic          m_we = 1'b0, m_sel = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  bit            live = 1'b0;

  wb_port_arbiter #(.DW(DW), .AW(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .wb_sel     (wb_sel),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_we      (wb_we),
    .starve_cnt (starve_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Who should win this cycle, returned as {grant_b, grant_a}.
  function automatic logic [1:0] model_grant();
    if (!rst_n) return 2'b00;
    if (a_valid && b_valid) begin
      if (m_wait >= LIMIT) return 2'b10;              // B has waited long enough
      if (a_addr == b_addr && a_addr != 0) return 2'b10; // older B lands first
      return 2'b01;
    end
    return {b_valid, a_valid};
  endfunction

  always @(posedge clk) begin
    logic [1:0] g;
    g = model_grant();
    if (!rst_n) begin
      live   <= 1'b1;
      m_wait <= 0;
      m_we   <= 1'b0;
      m_sel  <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
    end else begin
      if (!b_valid || g[1]) m_wait <= 0;
      else m_wait <= (m_wait < 15) ? m_wait + 1 : 15;
      if (g[1]) begin
        m_we <= (b_addr != 0); m_sel <= 1'b1; m_addr <= b_addr; m_data <= b_data;
      end else if (g[0]) begin
        m_we <= (a_addr != 0); m_sel <= 1'b0; m_addr <= a_addr; m_data <= a_data;
      end else begin
        m_we <= 1'b0;
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    logic [1:0] g;
    if (live) begin
      g = model_grant();
      check("a_ready", 32'(a_ready), 32'(g[0]));
      check("b_ready", 32'(b_ready), 32'(g[1]));
      check("wb_we", 32'(wb_we), 32'(m_we));
      check("wb_sel", 32'(wb_sel), 32'(m_sel));
      check("wb_addr", 32'(wb_addr), 32'(m_addr));
      check("wb_data", wb_data, m_data);
      check("starve_cnt", 32'(starve_cnt), 32'(m_wait));
    end
  end

  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);

    // Reset held with both sources requesting.
    step(); step();
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_starve", 32'(starve_cnt), 32'd0);
    rst_n = 1'b1;
    #1;
    check("first_grant_a", 32'(a_ready), 32'd1);
    check("first_grant_b", 32'(b_ready), 32'd0);

    // Single source A.
    step();
    drive(1'b1, 5'd8, 32'h1234, 1'b0, 5'd0, 32'h0);
    #1;
    check("single_a_ready", 32'(a_ready), 32'd1);
    step();
    check("single_we", 32'(wb_we), 32'd1);
    check("single_sel", 32'(wb_sel), 32'd0);
    check("single_addr", 32'(wb_addr), 32'd8);
    check("single_data", wb_data, 32'h1234);

    // Write to the zero register is accepted but not written.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    check("zero_b_ready", 32'(b_ready), 32'd1);
    step();
    check("zero_we", 32'(wb_we), 32'd0);
    check("zero_sel", 32'(wb_sel), 32'd1);

    // Same destination: B first, then A.
    drive(1'b1, 5'd3, 32'd1, 1'b1, 5'd3, 32'd2);
    #1;
    check("waw_b_ready", 32'(b_ready), 32'd1);
    check("waw_a_ready", 32'(a_ready), 32'd0);
    step();
    check("waw_first_data", wb_data, 32'd2);
    check("waw_first_sel", 32'(wb_sel), 32'd1);
    drive(1'b1, 5'd3, 32'd1, 1'b0, 5'd0, 32'd0);
    #1;
    check("waw_a_ready2", 32'(a_ready), 32'd1);
    step();
    check("waw_second_data", wb_data, 32'd1);
    check("waw_second_we", 32'(wb_we), 32'd1);

    // Starvation guard: A always wins until B has waited LIMIT cycles.
    drive(1'b1, 5'd4, 32'hA4, 1'b1, 5'd9, 32'hB9);
    #1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("starve_a_ready_%0d", k), 32'(a_ready), (k != 4) ? 32'd1 : 32'd0);
      check($sformatf("starve_b_ready_%0d", k), 32'(b_ready), (k == 4) ? 32'd1 : 32'd0);
      step();
      check($sformatf("starve_cnt_%0d", k), 32'(starve_cnt),
            (k < 4) ? 32'(k + 1) : ((k == 4) ? 32'd0 : 32'd1));
    end

    // Reset lands in the same cycle as an A handshake.
    drive(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("midrst_a_ready", 32'(a_ready), 32'd0);
    step();
    check("midrst_we", 32'(wb_we), 32'd0);
    check("midrst_addr", 32'(wb_addr), 32'd0);
    check("midrst_data", wb_data, 32'd0);
    check("midrst_sel", 32'(wb_sel), 32'd0);
    check("midrst_starve", 32'(starve_cnt), 32'd0);
    rst_n = 1'b1;

    // Random traffic against the reference model; small address range so
    // WAW collisions and zero-register writes occur often.
    for (int i = 0; i < 3000; i++) begin
      step();
      rst_n = ($urandom_range(0, 249) != 0);
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 4) != 0, 5'($urandom_range(0, 3)), $urandom);
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
